weight_row_fetcher: RTL and testbench

Read-side initiator for the fully-connected layer weight ROM. On a start pulse it walks ROM addresses 0..INPUT_NODES-1 and returns each OUTPUT_NODES-wide weight row on a valid/ready stream to the downstream MAC array. It absorbs the ROM's one-cycle registered read latency and downstream backpressure through an internal credit-controlled FIFO. It sits between the FC controller and the weight ROM, one instance per FC layer.

---
 rtl/cnn_pkg.sv | 8 +
 rtl/weight_row_fifo.sv | 44 ++++
 rtl/weight_row_fetcher.sv | 81 ++++++++
 tb/tb_weight_row_fetcher.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants and state type for the FC-layer weight fetch path.
package cnn_pkg;
    localparam int ADDR_WIDTH = 11;
    localparam logic [ADDR_WIDTH-1:0] PARK_ADDR = 11'h7FF;
    localparam int FETCH_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/weight_row_fifo.sv
// weight_row_fifo: small synchronous FIFO whose head word feeds the row stream directly.
module weight_row_fifo
    import cnn_pkg::*;
#(
    parameter int WIDTH = 1036,
    parameter int DEPTH = FETCH_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    assign head  = mem[rd_ptr];
    assign empty = count == '0;
    assign full  = count == CW'(DEPTH);

    // Storage is cleared too, so the stream outputs read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/weight_row_fetcher.sv
// weight_row_fetcher: streams weight ROM rows 0..INPUT_NODES-1 to the MAC array,
// hiding the ROM's registered read latency behind a credit-checked FIFO.
module weight_row_fetcher
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int INPUT_NODES  = 100,
    parameter int OUTPUT_NODES = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [ADDR_WIDTH-1:0]              mem_address,
    input  logic [DATA_WIDTH*OUTPUT_NODES-1:0] mem_weights,
    output logic [DATA_WIDTH*OUTPUT_NODES-1:0] row_data,
    output logic [ADDR_WIDTH-1:0]              row_index,
    output logic                               row_last,
    output logic                               row_valid,
    input  logic                               row_ready
);
    localparam int ROW_W = DATA_WIDTH * OUTPUT_NODES;
    localparam int CW = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(INPUT_NODES - 1);

    fetch_state_t state, state_next;
    logic [ADDR_WIDTH-1:0] issue_cnt, issue_addr, s2_idx;
    logic s1, s2, issue, pop, drained, empty, full;
    logic [CW-1:0] count;
    logic [ROW_W+ADDR_WIDTH:0] head;

    assign row_valid = !empty;
    assign pop = row_valid && row_ready;
    assign {row_data, row_index, row_last} = head;
    assign busy = state != IDLE;
    assign drained = empty && !s1 && !s2;

    always_comb begin
        issue_addr = (state == IDLE) ? '0 : issue_cnt;
        // Rows already in the ROM pipe need a reserved slot: the ROM output is never held.
        issue = (state == IDLE) ? start
              : (state == FETCH) && (int'(count) - int'(pop) + int'(s1) + int'(s2) < FETCH_FIFO_DEPTH);
        done = (state == DRAIN) && drained;
        state_next = (issue && issue_addr == LAST_ROW) ? DRAIN
                   : (issue && state == IDLE) ? FETCH
                   : done ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            issue_cnt   <= '0;
            mem_address <= PARK_ADDR;
            s1          <= 1'b0;
            s2          <= 1'b0;
            s2_idx      <= '0;
        end else begin
            state       <= state_next;
            mem_address <= issue ? issue_addr : PARK_ADDR;
            s1          <= issue;
            s2          <= s1;
            s2_idx      <= mem_address;
            if (issue) issue_cnt <= issue_addr + 1'b1;
        end
    end

    weight_row_fifo #(.WIDTH(ROW_W + ADDR_WIDTH + 1), .DEPTH(FETCH_FIFO_DEPTH)) fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s2),
        .pop       (pop),
        .push_data ({mem_weights, s2_idx, s2_idx == LAST_ROW}),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk) if (!reset) assert (!(s2 && full && !pop));
endmodule

// File: tb/tb_weight_row_fetcher.sv
// tb_weight_row_fetcher: three fetchers (4, 100 and 1 rows) against a ROM model and a row-order scoreboard.
module tb_weight_row_fetcher;
    localparam int DW = 32;
    localparam int ON = 4;
    localparam int W = DW * ON;
    localparam int NS [3] = '{4, 100, 1};
    localparam logic [W-1:0] ROW_ONES = 128'h00000001_00000001_00000001_00000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3], start [3], rdy [3], busy [3], done [3], row_v [3], row_l [3];
    logic [10:0] mem_a [3], row_i [3];
    logic [W-1:0] mem_w [3], row_d [3];
    int errors = 0, checks = 0;

    int exp_idx [3], iss [3], hs_cnt [3], done_cnt [3];
    bit busy_e [3], last_hs [3], hold [3];

    function automatic logic [W-1:0] rom(int g, int r);
        logic [W-1:0] v;
        for (int k = 0; k < ON; k++) v[W-1-32*k -: 32] = (g == 1) ? 32'((r + 1) * 16 + k) : 32'(r + 1);
        return v;
    endfunction

    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : inst
        weight_row_fetcher #(.DATA_WIDTH(DW), .INPUT_NODES(NS[g]), .OUTPUT_NODES(ON)) dut (
            .clk(clk), .reset(rst[g]), .start(start[g]), .busy(busy[g]), .done(done[g]),
            .mem_address(mem_a[g]), .mem_weights(mem_w[g]), .row_data(row_d[g]),
            .row_index(row_i[g]), .row_last(row_l[g]), .row_valid(row_v[g]), .row_ready(rdy[g]));
    end

    always @(posedge clk)
        for (int g = 0; g < 3; g++)
            mem_w[g] <= (int'(mem_a[g]) < NS[g]) ? rom(g, int'(mem_a[g])) : '0;

    // Rule model: rows 0..N-1 in order, done the cycle after the last row's handshake.
    always @(negedge clk) begin
        bit done_e;
        for (int g = 0; g < 3; g++) begin
            if (rst[g]) begin
                chk("rst_ctl", W'({busy[g], done[g], row_v[g], row_l[g], row_i[g], mem_a[g]}),
                    W'({4'b0, 11'd0, 11'h7FF}));
                chk("rst_data", row_d[g], '0);
                {busy_e[g], last_hs[g], hold[g]} = '0;
                exp_idx[g] = 0; iss[g] = 0; hs_cnt[g] = 0;
            end else begin
                done_e = last_hs[g];
                chk("busy", W'(busy[g]), W'(busy_e[g]));
                chk("done", W'(done[g]), W'(done_e));
                if (mem_a[g] != 11'h7FF) begin
                    chk("issue_addr", W'(mem_a[g]), W'(iss[g]));
                    chk("addr_range", W'(int'(mem_a[g]) < NS[g]), W'(1));
                    iss[g]++;
                    chk("in_flight", W'(iss[g] - exp_idx[g] <= 4), W'(1));
                end
                if (hold[g]) chk("hold_valid", W'(row_v[g]), W'(1));
                last_hs[g] = 0;
                if (row_v[g]) begin
                    chk("row_index", W'(row_i[g]), W'(exp_idx[g]));
                    chk("row_data", row_d[g], rom(g, exp_idx[g]));
                    chk("row_last", W'(row_l[g]), W'(exp_idx[g] == NS[g] - 1));
                    if (rdy[g]) begin
                        last_hs[g] = exp_idx[g] == NS[g] - 1;
                        exp_idx[g]++;
                        hs_cnt[g]++;
                    end
                end
                hold[g] = row_v[g] && !rdy[g];
                if (done[g]) done_cnt[g]++;
                if (!busy_e[g] && start[g]) begin
                    exp_idx[g] = 0; iss[g] = 0; hs_cnt[g] = 0;
                end
                busy_e[g] = busy_e[g] ? !done_e : start[g];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int g, int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            seen = done[g];
            if (!seen) step();
        end
        chk($sformatf("done_seen%0d", g), W'(seen), W'(1));
        step();
    endtask

    // {mem_address, row_valid, row_last, done, busy} for cycles 1..8 of the basic pass
    localparam logic [14:0] BASIC [1:8] = '{
        {11'd0, 4'b0001}, {11'd1, 4'b0001}, {11'd2, 4'b1001}, {11'd3, 4'b1001},
        {11'h7FF, 4'b1001}, {11'h7FF, 4'b1101}, {11'h7FF, 4'b0011}, {11'h7FF, 4'b0000}};

    initial begin
        int d0;
        bit seen;
        for (int g = 0; g < 3; g++) begin rst[g] = 1; start[g] = 0; rdy[g] = 1; end
        step(); step();
        for (int g = 0; g < 3; g++) rst[g] = 0;
        step();

        start[0] = 1; step(); start[0] = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("basic_ctl_c%0d", c),
                W'({mem_a[0], row_v[0], row_l[0], done[0], busy[0]}), W'(BASIC[c]));
            if (c >= 3 && c <= 6) chk($sformatf("basic_idx_c%0d", c), W'(row_i[0]), W'(c - 3));
            if (c == 3) chk("basic_data_c3", row_d[0], ROW_ONES);
            if (c == 6) chk("basic_data_c6", row_d[0], 128'h00000004_00000004_00000004_00000004);
            step();
        end

        start[0] = 1; step(); start[0] = 0;
        step(); step();
        rdy[0] = 0;
        for (int c = 3; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_c%0d", c), W'({row_v[0], row_i[0]}), W'({1'b1, 11'd0}));
            chk($sformatf("bp_data_c%0d", c), row_d[0], ROW_ONES);
            if (c >= 5) chk($sformatf("bp_park_c%0d", c), W'(mem_a[0]), W'(11'h7FF));
            step();
        end
        rdy[0] = 1;
        wait_done(0, 20);
        chk("bp_rows", W'(hs_cnt[0]), W'(4));

        d0 = done_cnt[0];
        start[0] = 1; step(); start[0] = 0;
        step(); step(); step();
        start[0] = 1; step(); start[0] = 0;
        wait_done(0, 20);
        repeat (4) step();
        chk("ign_one_done", W'(done_cnt[0] - d0), W'(1));
        chk("ign_rows", W'(hs_cnt[0]), W'(4));
        chk("ign_idle", W'(busy[0]), W'(0));

        d0 = done_cnt[0];
        start[0] = 1; step(); start[0] = 0;
        repeat (4) step();
        rst[0] = 1;
        @(negedge clk);
        chk("rst_mid_out", W'({busy[0], done[0], row_v[0], mem_a[0]}), W'({3'b000, 11'h7FF}));
        step(); step();
        rst[0] = 0;
        step();
        chk("rst_no_done", W'(done_cnt[0] - d0), W'(0));
        start[0] = 1; step(); start[0] = 0;
        wait_done(0, 20);
        step();
        chk("rst_rerun_rows", W'(hs_cnt[0]), W'(4));
        chk("rst_rerun_done", W'(done_cnt[0] - d0), W'(1));

        d0 = done_cnt[1];
        start[1] = 1; step(); start[1] = 0;
        seen = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            rdy[1] = 1'($urandom_range(0, 1));
            @(negedge clk);
            seen = done[1];
            step();
        end
        rdy[1] = 1;
        chk("rand_done_seen", W'(seen), W'(1));
        step();
        chk("rand_rows", W'(hs_cnt[1]), W'(100));
        chk("rand_one_done", W'(done_cnt[1] - d0), W'(1));

        start[2] = 1; step(); start[2] = 0;
        @(negedge clk); chk("n1_addr_c1", W'(mem_a[2]), W'(11'd0)); step();
        @(negedge clk); chk("n1_addr_c2", W'(mem_a[2]), W'(11'h7FF)); step();
        @(negedge clk);
        chk("n1_row_c3", W'({row_v[2], row_l[2], row_i[2], done[2]}), W'({2'b11, 11'd0, 1'b0}));
        chk("n1_data_c3", row_d[2], ROW_ONES);
        step();
        @(negedge clk); chk("n1_done_c4", W'({done[2], busy[2]}), W'(2'b11)); step();
        @(negedge clk); chk("n1_idle_c5", W'({done[2], busy[2]}), W'(2'b00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
